// File: rtl/overlap_add_manager.sv
// rtl/overlap_add_manager.sv - 50% overlap-add reconstruction of N-sample synthesis frames
//
// Purpose: takes frames of N = 2^ADDRWIDTH signed samples, sums the first
// half of each frame with the stored second half (the tail) of the previous
// frame, and emits H = N/2 saturated samples per frame.  The second half of
// each frame is stored as the next tail.  A flush at a frame boundary drains
// the stored tail as a final H-sample burst.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    input frame sample valid
//   in_ready    input sample accepted when in_valid && in_ready
//   in_data     signed frame sample, index order 0..N-1
//   window_addr index of the next input sample (synthesis window LUT address)
//   flush       request to drain the stored tail
//   out_valid   output sample valid
//   out_ready   downstream accepts when out_valid && out_ready
//   out_data    reconstructed signed sample
//   out_last    last sample of a flush drain
//   flush_done  one-cycle pulse when a flush completes
module overlap_add_manager #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic [ADDRWIDTH-1:0] window_addr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 flush_done
);

  localparam int H  = 1 << (ADDRWIDTH - 1);
  localparam int HW = ADDRWIDTH - 1;
  localparam logic [ADDRWIDTH-1:0] IDX_HM1  = ADDRWIDTH'(H - 1);
  localparam logic [ADDRWIDTH-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {ST_FIRST, ST_SECOND, ST_FLUSH} state_t;

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] idx, idx_nxt;
  logic                 primed;
  logic                 alive;   // holds in_ready low until the first edge after reset
  logic [DATAWIDTH-1:0] tail_mem [H];
  logic [DATAWIDTH-1:0] tail_q;  // prefetched tail[idx_nxt], valid when idx is reached
  logic [DATAWIDTH-1:0] addend;
  logic [DATAWIDTH-1:0] sum_sat;

  logic in_acc, out_free, idx_zero;
  logic flush_start, flush_nop, flush_emit, flush_end;

  function automatic logic [DATAWIDTH-1:0] sat_add(input logic [DATAWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] b);
    logic [DATAWIDTH:0] s;
    s = {a[DATAWIDTH-1], a} + {b[DATAWIDTH-1], b};
    // Overflow shows as disagreement between the extra sign bit and the MSB.
    if (s[DATAWIDTH] != s[DATAWIDTH-1])
      sat_add = s[DATAWIDTH] ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
    else
      sat_add = s[DATAWIDTH-1:0];
  endfunction

  assign window_addr = idx;
  assign in_acc      = in_valid && in_ready;
  assign out_free    = !out_valid || out_ready;
  assign idx_zero    = (idx == '0);
  assign flush_start = (state == ST_FIRST) && idx_zero && primed && flush;
  assign flush_nop   = (state == ST_FIRST) && idx_zero && !primed && flush;
  // idx doubles as the drain counter; idx == H marks "all tail samples issued".
  assign flush_emit  = (state == ST_FLUSH) && !idx[ADDRWIDTH-1] && out_free;
  assign flush_end   = (state == ST_FLUSH) && out_valid && out_ready && out_last;
  assign addend      = primed ? tail_q : '0;
  assign sum_sat     = sat_add(in_data, addend);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_FIRST;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_FIRST: begin
        if (flush_start) begin
          state_nxt = ST_FLUSH;
        end else if (in_acc) begin
          idx_nxt = idx + 1'b1;
          if (idx == IDX_HM1) state_nxt = ST_SECOND;
        end
      end
      ST_SECOND: begin
        if (in_acc) begin
          idx_nxt = idx + 1'b1;
          if (idx == IDX_LAST) state_nxt = ST_FIRST;
        end
      end
      ST_FLUSH: begin
        if (flush_emit) idx_nxt = idx + 1'b1;
        if (flush_end) begin
          idx_nxt   = '0;
          state_nxt = ST_FIRST;
        end
      end
      default: begin
        state_nxt = ST_FIRST;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_FIRST:  in_ready = alive && out_free && !flush_start;
      ST_SECOND: in_ready = alive;
      default:   in_ready = 1'b0;
    endcase
  end

  // Output register, primed flag, tail prefetch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
      primed     <= 1'b0;
      alive      <= 1'b0;
      tail_q     <= '0;
    end else begin
      alive      <= 1'b1;
      flush_done <= flush_end || flush_nop;
      tail_q     <= tail_mem[idx_nxt[HW-1:0]];

      if (state == ST_FIRST && in_acc) begin
        out_valid <= 1'b1;
        out_data  <= sum_sat;
        out_last  <= 1'b0;
      end else if (flush_emit) begin
        out_valid <= 1'b1;
        out_data  <= tail_q;
        out_last  <= (idx == IDX_HM1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (flush_end)
        primed <= 1'b0;
      else if (state == ST_SECOND && in_acc)
        primed <= 1'b1;
    end
  end

  // Tail memory write port (idx - H has the same low bits as idx).
  always_ff @(posedge clock) begin
    if (state == ST_SECOND && in_acc)
      tail_mem[idx[HW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_overlap_add_manager.sv
// tb/tb_overlap_add_manager.sv - directed self-checking bench for overlap_add_manager
module tb_overlap_add_manager;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] window_addr;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       flush_done;

  overlap_add_manager #(.ADDRWIDTH(3), .DATAWIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .window_addr (window_addr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .flush_done  (flush_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int act_d[$];
  int act_l[$];
  int exp_d[$];
  int exp_l[$];
  int rd_ptr  = 0;
  int fd_cnt  = 0;
  int fd_cyc  = 0;
  int last_cyc = 0;
  int fr[8];

  always @(posedge clock) cyc++;

  // Handshakes are observed mid-cycle, where inputs and outputs are stable.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      act_d.push_back(int'($signed(out_data)));
      act_l.push_back(int'(out_last));
      if (out_last) last_cyc = cyc;
    end
    if (reset && flush_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_out(input int d, input int l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = act_d.size() - rd_ptr;
    check({tag, "_count"}, n, exp_d.size());
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      check({tag, "_data"}, act_d[rd_ptr + i], exp_d[i]);
      check({tag, "_last"}, act_l[rd_ptr + i], exp_l[i]);
    end
    rd_ptr = act_d.size();
    exp_d.delete();
    exp_l.delete();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_sample(input int d, input int exp_addr);
    int  waited;
    bit  done;
    waited   = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        check("window_addr", int'(window_addr), exp_addr);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 20) begin
          check("in_ready_timeout", 0, 1);
          done = 1'b1;
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < 8; i++) push_sample(fr[i], i);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_flush_done"}, int'(flush_done), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_window_addr"}, int'(window_addr), 0);
  endtask

  task automatic wait_flush_done(input int fd0);
    int waited;
    waited = 0;
    while (fd_cnt == fd0 && waited < 30) begin
      wait_cycles(1);
      waited++;
    end
    check("flush_done_seen", fd_cnt - fd0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int fd0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    wait_cycles(3);
    check_reset_state("reset");
    reset = 1'b1;
    #0;
    check("in_ready_before_edge", int'(in_ready), 0);

    // Frame 1 with zero tail
    fr = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_frame();
    check("window_addr_wrap", int'(window_addr), 0);
    expect_out(1, 0); expect_out(2, 0); expect_out(3, 0); expect_out(4, 0);
    wait_cycles(2);
    check_outputs("frame1");

    // Frame 2 sums with tail 5..8
    fr = '{10, 20, 30, 40, 100, -100, 0, 0};
    send_frame();
    expect_out(15, 0); expect_out(26, 0); expect_out(37, 0); expect_out(48, 0);
    wait_cycles(2);
    check_outputs("frame2");

    // Saturation both directions
    fr = '{100, -100, 1, 2, 5, 6, 7, 8};
    send_frame();
    expect_out(127, 0); expect_out(-128, 0); expect_out(1, 0); expect_out(2, 0);
    wait_cycles(2);
    check_outputs("sat");

    // Flush together with in_valid at idx 0
    fd0      = fd_cnt;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clock);
    check("flush_blocks_input", int'(in_ready), 0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    wait_flush_done(fd0);
    check("flush_done_latency", fd_cyc - last_cyc, 1);
    wait_cycles(2);
    check("flush_done_single", fd_cnt - fd0, 1);
    check("flush_idx_zero", int'(window_addr), 0);
    expect_out(5, 0); expect_out(6, 0); expect_out(7, 0); expect_out(8, 1);
    check_outputs("flush");

    // Flush with primed == 0: pulse only
    fd0   = fd_cnt;
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    check("nop_flush_pulse_now", int'(flush_done), 1);
    wait_cycles(3);
    check("nop_flush_count", fd_cnt - fd0, 1);
    check_outputs("nop_flush");

    // Next frame sums with zero tail
    fr = '{3, 4, 5, 6, 7, 7, 7, 7};
    send_frame();
    expect_out(3, 0); expect_out(4, 0); expect_out(5, 0); expect_out(6, 0);
    wait_cycles(2);
    check_outputs("post_flush");

    // Backpressure in FIRST
    out_ready = 1'b0;
    push_sample(1, 0);
    in_valid = 1'b1;
    in_data  = 8'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'($signed(out_data)), 8);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    fr = '{1, 2, 3, 4, 50, 50, 50, 50};
    for (int i = 1; i < 8; i++) push_sample(fr[i], i);
    in_valid = 1'b0;
    expect_out(8, 0); expect_out(9, 0); expect_out(10, 0); expect_out(11, 0);
    wait_cycles(2);
    check_outputs("backpressure");

    // Reset mid-SECOND
    push_sample(1, 0); push_sample(2, 1); push_sample(3, 2); push_sample(4, 3);
    push_sample(60, 4); push_sample(61, 5);
    in_valid = 1'b0;
    expect_out(51, 0); expect_out(52, 0); expect_out(53, 0); expect_out(54, 0);
    wait_cycles(2);
    check_outputs("pre_reset");
    reset = 1'b0;
    #2;
    check_reset_state("mid_reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    fr = '{9, 10, 11, 12, 0, 0, 0, 0};
    send_frame();
    expect_out(9, 0); expect_out(10, 0); expect_out(11, 0); expect_out(12, 0);
    wait_cycles(2);
    check_outputs("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
